// File: rtl/fwrisc_dbus_wb.sv
`timescale 1ns/1ps
// fwrisc data-port to Wishbone B4 classic master bridge, with bus-timeout and AMO-reject error reporting.
// stb the cycle after dvalid; dready the cycle after ack/err/timeout (AMO reject: dready the cycle after dvalid).
module fwrisc_dbus_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    input  logic [3:0]  damo,
    output logic [31:0] drdata,
    output logic        dready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen in the last allowed BUS cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        addr_q;
    logic [31:0]        adr_q;
    logic [31:0]        dat_q;
    logic [3:0]         sel_q;
    logic               we_q;
    logic               cyc_q;
    logic [31:0]        drdata_q;
    logic               dready_q;
    logic               bus_err_q;
    logic [31:0]        err_addr_q;
    logic               timeout_hit;

    assign cnt_d       = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            drdata_q   <= '0;
            dready_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            dready_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dvalid) begin
                        addr_q <= daddr;
                        if (damo != 4'h0) begin
                            // Atomics are not supported on this bus: fail without a cycle.
                            state_q    <= RESP;
                            drdata_q   <= '0;
                            dready_q   <= 1'b1;
                            bus_err_q  <= 1'b1;
                            err_addr_q <= daddr;
                        end else begin
                            state_q <= BUS;
                            cnt_q   <= '0;
                            cyc_q   <= 1'b1;
                            adr_q   <= {daddr[31:2], 2'b00};
                            dat_q   <= dwdata;
                            we_q    <= dwrite;
                            sel_q   <= dwrite ? dwstb : 4'hF;
                        end
                    end
                end
                BUS: begin
                    if (wb_err_i) begin
                        // err takes priority even when ack is asserted alongside it.
                        state_q    <= RESP;
                        cyc_q      <= 1'b0;
                        drdata_q   <= '0;
                        dready_q   <= 1'b1;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                    end else if (wb_ack_i) begin
                        state_q  <= RESP;
                        cyc_q    <= 1'b0;
                        drdata_q <= we_q ? 32'h0 : wb_dat_i;
                        dready_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q    <= RESP;
                        cyc_q      <= 1'b0;
                        drdata_q   <= '0;
                        dready_q   <= 1'b1;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign drdata   = drdata_q;
    assign dready   = dready_q;
    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;

endmodule
